// File: rtl/avmm_read_responder_if.sv
// ----------------------------------------------------------------------------
// avmm_read_responder_if
// Avalon-MM read-only bus between the fill master and the table responder.
//
// Signals
//   address        master -> slave  word address of the read
//   read           master -> slave  read request, held by the master while stalled
//   waitrequest    slave -> master  1 = request not accepted this cycle
//   readdata       slave -> master  returned word, holds between responses
//   readdatavalid  slave -> master  readdata/response valid this cycle
//   response       slave -> master  2'b00 OKAY, 2'b10 SLAVEERROR
//   pending        slave -> master  outstanding-read count (debug)
// ----------------------------------------------------------------------------
interface avmm_read_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int PEND_WIDTH = 2
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  waitrequest;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic [1:0]            response;
    logic [PEND_WIDTH-1:0] pending;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata,
        input  readdatavalid,
        input  response,
        input  pending
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata,
        output readdatavalid,
        output response,
        output pending
    );
endinterface

// File: rtl/avmm_read_responder.sv
// ----------------------------------------------------------------------------
// avmm_read_responder
// Avalon-MM read-only slave returning words from a constant on-chip table.
// Word 0 holds vector B, words 1..8 hold rows A0..A7 for the matrix-vector
// fill master. Reads are fixed-latency, in-order and pipelined; waitrequest
// caps the number of outstanding reads at MAX_PENDING.
//
// The table image is supplied through INIT_TABLE (word i in bits
// [i*DATA_WIDTH +: DATA_WIDTH]) so the contents are fixed at elaboration.
//
// Ports
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of avmm_read_responder_if
//          (address, read, waitrequest, readdata, readdatavalid,
//           response, pending)
// ----------------------------------------------------------------------------
module avmm_read_responder #(
    parameter int                          DATA_WIDTH   = 64,
    parameter int                          ADDR_WIDTH   = 32,
    parameter int                          DEPTH        = 16,
    parameter int                          READ_LATENCY = 2,
    parameter int                          MAX_PENDING  = 2,
    parameter logic [DEPTH*DATA_WIDTH-1:0] INIT_TABLE   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    avmm_read_responder_if.slave  bus
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    typedef enum logic {
        S_INIT,
        S_SERVE
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic                    w_waitrequest;
    logic                    w_accept;
    logic                    w_addrError;
    logic                    w_respond;
    logic [IDX_W-1:0]        w_index;
    logic [DATA_WIDTH-1:0]   w_tableWord;
    logic [READ_LATENCY-1:0] r_pipeValid;
    logic [READ_LATENCY-1:0] r_pipeError;
    logic [DATA_WIDTH-1:0]   r_pipeData [READ_LATENCY];
    logic [PEND_W-1:0]       r_pending;

    // State register: reset always lands in INIT, which holds off the
    // master for one clock after rst_n is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and waitrequest. waitrequest depends only on state and
    // the outstanding count, never on read, so the master cannot form a
    // combinational loop through it.
    always_comb begin
        w_nextState   = r_state;
        w_waitrequest = 1'b1;
        case (r_state)
            S_INIT: begin
                w_nextState   = S_SERVE;
                w_waitrequest = 1'b1;
            end
            S_SERVE: begin
                w_nextState   = S_SERVE;
                w_waitrequest = (r_pending == PEND_W'(MAX_PENDING));
            end
        endcase
    end

    // Range check uses the full address so out-of-range addresses never
    // alias onto a table word through the truncated index.
    assign w_accept    = bus.read & ~w_waitrequest;
    assign w_addrError = (bus.address >= ADDR_WIDTH'(DEPTH));
    assign w_index     = bus.address[IDX_W-1:0];
    assign w_tableWord = w_addrError ? '0
                                     : INIT_TABLE[int'(w_index)*DATA_WIDTH +: DATA_WIDTH];

    // Latency pipeline. Stage 0 captures the table word on the accept
    // edge; later stages only move data forward when a valid entry moves,
    // so the last stage (and thus readdata) holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipeValid <= '0;
            r_pipeError <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipeData[i] <= '0;
            end
        end else begin
            r_pipeValid[0] <= w_accept;
            r_pipeError[0] <= w_accept & w_addrError;
            if (w_accept) begin
                r_pipeData[0] <= w_tableWord;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                r_pipeError[i] <= r_pipeError[i-1];
                if (r_pipeValid[i-1]) begin
                    r_pipeData[i] <= r_pipeData[i-1];
                end
            end
        end
    end

    assign w_respond = r_pipeValid[READ_LATENCY-1];

    // Outstanding-read counter: an accept and a response in the same
    // cycle cancel. Accepts are blocked at MAX_PENDING and responses only
    // exist for accepted reads, so it cannot overflow or underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (w_accept && !w_respond) begin
            r_pending <= r_pending + PEND_W'(1);
        end else if (!w_accept && w_respond) begin
            r_pending <= r_pending - PEND_W'(1);
        end
    end

    assign bus.waitrequest   = w_waitrequest;
    assign bus.readdatavalid = w_respond;
    assign bus.readdata      = r_pipeData[READ_LATENCY-1];
    assign bus.response      = (w_respond && r_pipeError[READ_LATENCY-1]) ? 2'b10 : 2'b00;
    assign bus.pending       = r_pending;

endmodule
